// File: rtl/emesh_pkg.sv
// Shared EMesh definitions: packet field positions, the 104-bit packing
// function and the skid-buffer occupancy encoding.
package emesh_pkg;

  localparam int AW32 = 32;
  localparam int PW32 = 104;

  localparam int EM_WRITE_BIT = 0;
  localparam int EM_DMODE_LSB = 1;
  localparam int EM_CTRL_LSB  = 3;
  localparam int EM_RSVD_BIT  = 7;
  localparam int EM_DST_LSB   = 8;
  localparam int EM_DATA_LSB  = 40;
  localparam int EM_SRC_LSB   = 72;

  // Occupancy of the two-entry skid buffer; FULL means the skid register holds data.
  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_ONE   = 2'd1,
    SB_FULL  = 2'd2
  } skid_state_e;

  // ctrlmode[4] has no slot on the link and bit 7 is reserved as zero.
  function automatic logic [PW32-1:0] pack_emesh(
    input logic            write,
    input logic [1:0]      datamode,
    input logic [4:0]      ctrlmode,
    input logic [AW32-1:0] dstaddr,
    input logic [AW32-1:0] data,
    input logic [AW32-1:0] srcaddr
  );
    logic [PW32-1:0] pkt;
    pkt                       = '0;
    pkt[EM_WRITE_BIT]         = write;
    pkt[EM_DMODE_LSB +: 2]    = datamode;
    pkt[EM_CTRL_LSB +: 4]     = ctrlmode[3:0];
    pkt[EM_RSVD_BIT]          = 1'b0;
    pkt[EM_DST_LSB +: AW32]   = dstaddr;
    pkt[EM_DATA_LSB +: AW32]  = data;
    pkt[EM_SRC_LSB +: AW32]   = srcaddr;
    return pkt;
  endfunction

endpackage

// File: rtl/emesh_skid_buffer.sv
// Generic two-entry valid/wait skid buffer: an output register backed by a
// skid register, so in_wait is registered and never depends on out_wait.
module emesh_skid_buffer
  import emesh_pkg::*;
#(
  parameter int DW = 104
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_wait,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_wait,
  output skid_state_e   state_dbg
);

  // Handshake: a word enters when in_valid=1 and in_wait=0 at a rising edge;
  // a word leaves when out_valid=1 and out_wait=0. While out_valid=1 and
  // out_wait=1, out_valid and out_data hold stable.

  skid_state_e   state_q;
  skid_state_e   state_d;
  logic [DW-1:0] out_q;
  logic [DW-1:0] skid_q;
  logic          out_free;
  logic          accept;
  logic          skid_valid;

  assign skid_valid = (state_q == SB_FULL);
  assign out_free   = (state_q == SB_EMPTY) | ~out_wait;
  assign accept     = in_valid & ~in_wait;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SB_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_EMPTY: begin
        if (accept) state_d = SB_ONE;
      end
      SB_ONE: begin
        if (out_free) state_d = accept ? SB_ONE : SB_EMPTY;
        else if (accept) state_d = SB_FULL;
      end
      SB_FULL: begin
        if (out_free) state_d = accept ? SB_FULL : SB_ONE;
      end
      default: state_d = SB_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q != SB_EMPTY);
    in_wait   = (state_q == SB_FULL);
    state_dbg = state_q;
  end

  // The older skid entry always drains into the output register first.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (out_free) begin
        if (skid_valid) out_q <= skid_q;
        else if (accept) out_q <= in_data;
      end
      if (accept && (skid_valid || !out_free)) skid_q <= in_data;
    end
  end

  assign out_data = out_q;

endmodule

// File: rtl/emesh2packet_tx.sv
// EMesh transmit packer: packs an accepted EMesh bundle into a 104-bit
// packet and presents it through a two-entry skid buffer to the fabric.
module emesh2packet_tx
  import emesh_pkg::*;
#(
  parameter int AW = 32,
  parameter int PW = 104,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          access_in,
  input  logic          write_in,
  input  logic [1:0]    datamode_in,
  input  logic [4:0]    ctrlmode_in,
  input  logic [AW-1:0] dstaddr_in,
  input  logic [AW-1:0] srcaddr_in,
  input  logic [AW-1:0] data_in,
  output logic          wait_out,
  output logic          access_out,
  output logic [PW-1:0] packet_out,
  input  logic          wait_in,
  output logic [CW-1:0] pkt_count,
  output logic          err_ctrlmode
);

  logic [PW-1:0] packed_pkt;
  logic          accept;
  logic          xfer;
  logic [CW-1:0] pkt_count_q;
  logic          err_q;
  skid_state_e   skid_state;

  assign packed_pkt = pack_emesh(write_in, datamode_in, ctrlmode_in,
                                 dstaddr_in, data_in, srcaddr_in);
  assign accept     = access_in & ~wait_out;
  assign xfer       = access_out & ~wait_in;

  emesh_skid_buffer #(
    .DW(PW)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (access_in),
    .in_data  (packed_pkt),
    .in_wait  (wait_out),
    .out_valid(access_out),
    .out_data (packet_out),
    .out_wait (wait_in),
    .state_dbg(skid_state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (xfer) pkt_count_q <= pkt_count_q + CW'(1);
      if (accept && ctrlmode_in[4]) err_q <= 1'b1;
    end
  end

  assign pkt_count    = pkt_count_q;
  assign err_ctrlmode = err_q;

  // A full buffer always has a packet on the output and holds off the source.
  a_full_implies_busy: assert property (@(posedge clk) disable iff (reset)
    (skid_state == SB_FULL) |-> (access_out && wait_out));

endmodule

// File: tb/tb_emesh2packet_tx.sv
// Randomized self-checking bench for emesh2packet_tx with a queue-based
// reference model; a CW=4 instance covers counter wrap.
module tb_emesh2packet_tx;

  localparam int AW = 32;
  localparam int PW = 104;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          access_in;
  logic          write_in;
  logic [1:0]    datamode_in;
  logic [4:0]    ctrlmode_in;
  logic [AW-1:0] dstaddr_in;
  logic [AW-1:0] srcaddr_in;
  logic [AW-1:0] data_in;
  logic          wait_in;
  logic          wait_out, access_out, err_ctrlmode;
  logic [PW-1:0] packet_out;
  logic [CW-1:0] pkt_count;
  logic          wait_out_s, access_out_s, err_s;
  logic [PW-1:0] packet_out_s;
  logic [3:0]    pkt_count_s;

  emesh2packet_tx #(.AW(AW), .PW(PW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .access_in(access_in), .write_in(write_in),
    .datamode_in(datamode_in), .ctrlmode_in(ctrlmode_in), .dstaddr_in(dstaddr_in),
    .srcaddr_in(srcaddr_in), .data_in(data_in), .wait_out(wait_out),
    .access_out(access_out), .packet_out(packet_out), .wait_in(wait_in),
    .pkt_count(pkt_count), .err_ctrlmode(err_ctrlmode)
  );

  emesh2packet_tx #(.AW(AW), .PW(PW), .CW(4)) dut_small (
    .clk(clk), .reset(reset), .access_in(access_in), .write_in(write_in),
    .datamode_in(datamode_in), .ctrlmode_in(ctrlmode_in), .dstaddr_in(dstaddr_in),
    .srcaddr_in(srcaddr_in), .data_in(data_in), .wait_out(wait_out_s),
    .access_out(access_out_s), .packet_out(packet_out_s), .wait_in(wait_in),
    .pkt_count(pkt_count_s), .err_ctrlmode(err_s)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            errors = 0;
  int            checks = 0;
  logic [PW-1:0] exp_q[$];
  int            exp_count = 0;
  logic          exp_err = 1'b0;
  int            cyc = 0;
  int            xfer_cycles[$];
  int            wait_seen = 0;
  logic          prev_stall = 1'b0;
  logic [PW-1:0] prev_pkt;
  logic [PW-1:0] exp_v;

  // Reference packing straight from the field layout.
  function automatic logic [PW-1:0] model_pack(input logic w, input logic [1:0] dm,
      input logic [4:0] cm, input logic [31:0] dst, input logic [31:0] data,
      input logic [31:0] src);
    return {src, data, dst, 1'b0, cm[3:0], dm, w};
  endfunction

  // Output monitor: every transfer is popped from the expected queue in order.
  always @(negedge clk) begin
    cyc++;
    if (wait_out === 1'b1) wait_seen++;
    if (reset !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (access_out !== 1'b1 || packet_out !== prev_pkt) begin
          errors++;
          $display("FAIL hold: access_out=%b packet_out=%h required 1 %h", access_out, packet_out, prev_pkt);
        end
      end
      if (access_out === 1'b1 && wait_in === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL order: unexpected packet %h with empty queue", packet_out);
        end else begin
          exp_v = exp_q.pop_front();
          if (packet_out !== exp_v) begin
            errors++;
            $display("FAIL order: packet_out=%h required %h", packet_out, exp_v);
          end
        end
        exp_count++;
        xfer_cycles.push_back(cyc);
      end
      prev_stall = (access_out === 1'b1) && (wait_in === 1'b1);
      prev_pkt   = packet_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_pkt(input logic w, input logic [1:0] dm, input logic [4:0] cm,
      input logic [31:0] dst, input logic [31:0] data, input logic [31:0] src);
    access_in = 1'b1; write_in = w; datamode_in = dm; ctrlmode_in = cm;
    dstaddr_in = dst; data_in = data; srcaddr_in = src;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (wait_out === 1'b0) begin
        exp_q.push_back(model_pack(w, dm, cm, dst, data, src));
        if (cm[4]) exp_err = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL send_timeout: wait_out=%b required 0 within 200 cycles", wait_out);
    access_in = 1'b0;
  endtask

  task automatic send_rand();
    drive_pkt(1'($urandom), 2'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
  endtask

  task automatic drain();
    bit done = 0;
    access_in = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && access_out === 1'b0) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout: queue=%0d access_out=%b required 0 0", exp_q.size(), access_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_counts(input string tag);
    checks++;
    if (pkt_count !== CW'(exp_count)) begin
      errors++;
      $display("FAIL %s_count: pkt_count=%0d required %0d", tag, pkt_count, exp_count);
    end
    checks++;
    if (pkt_count_s !== 4'(exp_count)) begin
      errors++;
      $display("FAIL %s_count4: pkt_count=%0d required %0d", tag, pkt_count_s, 4'(exp_count));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; wait_in = 1'b0; access_in = 1'b1;
    write_in = 1'b1; datamode_in = 2'd1; ctrlmode_in = 5'h10;
    dstaddr_in = 32'h1; data_in = 32'h2; srcaddr_in = 32'h3;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; access_in = 1'b0;
    @(negedge clk);
    checks++; if (access_out !== 1'b0) begin errors++; $display("FAIL reset_access: got %b required 0", access_out); end
    checks++; if (wait_out !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b required 0", wait_out); end
    checks++; if (packet_out !== '0) begin errors++; $display("FAIL reset_packet: got %h required 0", packet_out); end
    checks++; if (err_ctrlmode !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err_ctrlmode); end
    check_counts("reset");
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    logic [PW-1:0] golden;
    golden = 104'h12345678_DEADBEEF_80000010_1D;
    wait_in = 1'b0;
    drive_pkt(1'b1, 2'd2, 5'h03, 32'h8000_0010, 32'hDEAD_BEEF, 32'h1234_5678);
    access_in = 1'b0;
    @(negedge clk);
    checks++; if (access_out !== 1'b1) begin errors++; $display("FAIL single_latency: access_out=%b required 1", access_out); end
    checks++; if (packet_out !== golden) begin errors++; $display("FAIL single_packet: got %h required %h", packet_out, golden); end
    @(posedge clk); #1;
    drain();
    check_counts("single");
  endtask

  task automatic test_back_to_back();
    int start_n;
    wait_in = 1'b0;
    wait_seen = 0;
    start_n = xfer_cycles.size();
    repeat (8) send_rand();
    drain();
    checks++;
    if (xfer_cycles.size() - start_n != 8) begin
      errors++; $display("FAIL b2b_transfers: got %0d required 8", xfer_cycles.size() - start_n);
    end else begin
      checks++;
      if (xfer_cycles[start_n+7] - xfer_cycles[start_n] != 7) begin
        errors++; $display("FAIL b2b_span: got %0d cycles required 7", xfer_cycles[start_n+7] - xfer_cycles[start_n]);
      end
    end
    checks++; if (wait_seen != 0) begin errors++; $display("FAIL b2b_wait: wait_out high %0d cycles required 0", wait_seen); end
    check_counts("b2b");
  endtask

  task automatic test_stall();
    bit rose = 0;
    wait_in = 1'b0;
    fork
      repeat (12) send_rand();
      begin
        repeat (3) @(posedge clk);
        #1 wait_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (i < 2 && wait_out === 1'b1) rose = 1;
          if (i == 4) begin
            checks++;
            if (wait_out !== 1'b1) begin errors++; $display("FAIL stall_full: wait_out=%b required 1", wait_out); end
          end
          @(posedge clk); #1;
        end
        wait_in = 1'b0;
        checks++; if (!rose) begin errors++; $display("FAIL stall_rise: wait_out=0 required 1 within 2 cycles"); end
        @(negedge clk);
        checks++; if (wait_out !== 1'b1) begin errors++; $display("FAIL stall_release0: wait_out=%b required 1", wait_out); end
        @(negedge clk);
        checks++; if (wait_out !== 1'b0) begin errors++; $display("FAIL stall_release1: wait_out=%b required 0", wait_out); end
      end
    join
    drain();
    check_counts("stall");
  endtask

  task automatic test_ctrlmode();
    wait_in = 1'b0;
    drive_pkt(1'b0, 2'd1, 5'h1A, $urandom, $urandom, $urandom);
    access_in = 1'b0;
    @(negedge clk);
    checks++; if (packet_out[7:3] !== 5'b01010) begin errors++; $display("FAIL ctrl_bits: got %b required 01010", packet_out[7:3]); end
    checks++; if (err_ctrlmode !== exp_err) begin errors++; $display("FAIL ctrl_err: got %b required %b", err_ctrlmode, exp_err); end
    @(posedge clk); #1;
    repeat (3) drive_pkt(1'($urandom), 2'($urandom), 5'($urandom_range(0, 15)), $urandom, $urandom, $urandom);
    drain();
    checks++; if (err_ctrlmode !== 1'b1) begin errors++; $display("FAIL ctrl_sticky: got %b required 1", err_ctrlmode); end
    check_counts("ctrl");
  endtask

  task automatic test_reset_mid();
    wait_in = 1'b1;
    send_rand();
    send_rand();
    access_in = 1'b0;
    @(negedge clk);
    checks++; if (wait_out !== 1'b1) begin errors++; $display("FAIL midrst_full: wait_out=%b required 1", wait_out); end
    @(posedge clk); #1;
    reset = 1'b1; access_in = 1'b1; ctrlmode_in = 5'h11;
    @(posedge clk); #1;
    reset = 1'b0; access_in = 1'b0; wait_in = 1'b0;
    exp_q.delete(); exp_count = 0; exp_err = 1'b0;
    @(negedge clk);
    checks++; if (access_out !== 1'b0) begin errors++; $display("FAIL midrst_access: got %b required 0", access_out); end
    checks++; if (wait_out !== 1'b0) begin errors++; $display("FAIL midrst_wait: got %b required 0", wait_out); end
    checks++; if (err_ctrlmode !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b required 0", err_ctrlmode); end
    check_counts("midrst");
    @(posedge clk); #1;
    send_rand();
    drain();
    check_counts("post_rst");
  endtask

  task automatic test_wrap();
    wait_in = 1'b0;
    while (exp_count + exp_q.size() < 15) send_rand();
    drain();
    check_counts("pre_wrap");
    send_rand();
    drain();
    checks++; if (pkt_count_s !== 4'd0) begin errors++; $display("FAIL wrap4: got %0d required 0", pkt_count_s); end
    check_counts("wrap");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    access_in = 1'b0; write_in = 1'b0; datamode_in = '0; ctrlmode_in = '0;
    dstaddr_in = '0; data_in = '0; srcaddr_in = '0; wait_in = 1'b0; reset = 1'b1;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_stall();
    test_ctrlmode();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    errors++; checks++;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
